// File: rtl/neuron_mac_seq.sv
// Single-neuron unsigned dot-product sequencer: operand buffer, 4x4 multiply, 10-bit accumulate.
// Optional build macro MAC_SAT_EN clamps the accumulator at 1023 instead of wrapping.
module neuron_mac_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_a,
    input  logic [3:0]    wr_b,
    input  logic [LW-1:0] len,
    input  logic          start,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [9:0]    result
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

    state_t        state, state_nx;
    logic [3:0]    a_mem [DEPTH];
    logic [3:0]    b_mem [DEPTH];
    logic [LW-1:0] count;
    logic [AW-1:0] idx;
    logic [9:0]    acc, acc_nx;
    logic [7:0]    prod;
    logic          last;

    assign prod   = {4'b0, a_mem[idx]} * {4'b0, b_mem[idx]};
    assign last   = (LW'(idx) == count - LW'(1));
    assign result = acc;

`ifdef MAC_SAT_EN
    logic [10:0] sum;
    assign sum    = {1'b0, acc} + {3'b0, prod};
    assign acc_nx = sum[10] ? '1 : sum[9:0];
`else
    assign acc_nx = acc + {2'b0, prod};
`endif

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        out_valid = (state == HOLD);
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (count == '0) ? HOLD : RUN;
            RUN:     if (last) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        a_mem[wr_addr] <= wr_a;
                        b_mem[wr_addr] <= wr_b;
                    end
                    if (start)
                        count <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                end
                CLEAR: begin
                    acc <= '0;
                    idx <= '0;
                end
                RUN: begin
                    acc <= acc_nx;
                    idx <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: stimulus pushes expected sums and valid-rise cycles,
// a negedge monitor pops and checks them when the DUT presents a result.
module tb_neuron_mac_seq;

    logic       clk = 0;
    logic       rst, wr_en, start, busy, out_valid, out_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_a, wr_b, len;
    logic [9:0] result;

`ifdef MAC_SAT_EN
    localparam int OVF = 1023;
`else
    localparam int OVF = 776;
`endif

    typedef struct {
        int res;
        int rise;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   in_hold = 0;
    bit   ack_prev = 0;

    neuron_mac_seq #(.DEPTH(8), .AW(3), .LW(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
        .len(len), .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops on the first HOLD cycle, checks stability while held, release after handshake.
    always @(negedge clk) begin
        if (rst) begin
            in_hold  = 0;
            ack_prev = 0;
        end else begin
            if (ack_prev) begin
                chk("release_valid", out_valid, 0);
                chk("release_busy", busy, 0);
                ack_prev = 0;
            end
            if (out_valid) begin
                if (!in_hold) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        in_hold = 1;
                        chk("valid_rise_cycle", cyc, cur.rise);
                    end
                end
                if (in_hold) begin
                    chk("result", result, cur.res);
                    chk("busy_in_hold", busy, 1);
                end
                if (out_ready) begin
                    ack_prev = 1;
                    in_hold  = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int addr, input int a, input int b);
        wr_en = 1; wr_addr = 3'(addr); wr_a = 4'(a); wr_b = 4'(b);
        tick();
        wr_en = 0;
    endtask

    task automatic start_run(input int l, input int res);
        exp_t e;
        start = 1; len = 4'(l);
        tick();
        start = 0;
        e.res  = res;
        e.rise = cyc + ((l > 8) ? 8 : l) + 1;
        exp_q.push_back(e);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || in_hold || busy) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        rst = 1; wr_en = 0; start = 0; out_ready = 1;
        wr_addr = '0; wr_a = '0; wr_b = '0; len = '0;
        tick(); tick();
        rst = 0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_result", result, 0);

        // basic run: 5+12+21+32
        for (int i = 0; i < 4; i++) write(i, i + 1, i + 5);
        start_run(4, 70);
        wait_done();
        chk("result_held_idle", result, 70);

        // overflow: 8 * 225 = 1800
        for (int i = 0; i < 8; i++) write(i, 15, 15);
        start_run(8, OVF);
        wait_done();

        start_run(0, 0);
        wait_done();

        start_run(12, OVF);
        wait_done();

        // backpressure with ignored start in HOLD
        for (int i = 0; i < 4; i++) write(i, i + 1, i + 5);
        out_ready = 0;
        start_run(4, 70);
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        chk("bp_valid_seen", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            len   = 4'd1;
            tick();
        end
        start = 0;
        chk("bp_still_valid", out_valid, 1);
        out_ready = 1;
        tick();
        chk("bp_idle_busy", busy, 0);
        wait_done();
        chk("bp_no_extra_run", busy, 0);

        // frozen buffer: write during RUN ignored
        start_run(4, 70);
        tick();
        write(0, 15, 15);
        wait_done();
        start_run(4, 70);
        wait_done();

        // reset mid-run discards the run and clears the buffer
        start_run(8, 0);
        tick(); tick(); tick();
        rst = 1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        exp_q.delete();
        rst = 0;
        tick();
        write(0, 2, 4);
        write(1, 3, 5);
        start_run(8, 23);
        wait_done();

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer that computes one neuron's unsigned dot product over a programmable number of 4-bit input/weight pairs. It holds the operands in an internal operand buffer, drives an embedded 4-bit multiply / 10-bit accumulate datapath one term per cycle, and presents the sum on a valid/ready output. It sits between the layer controller, which loads operands and issues `start`, and the downstream activation/collection logic.

## Interface
- `DEPTH`, default 8: operand buffer entries, i.e. the maximum number of terms.
- `AW`, default 3: address width, log2(`DEPTH`).
- `LW`, default 4: width of `len`; must be able to represent `DEPTH`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write the operand pair into the buffer at `wr_addr`.
- `wr_addr` in `AW`: buffer write address.
- `wr_a` in 4: input operand for the entry.
- `wr_b` in 4: weight operand for the entry.
- `len` in `LW`: number of terms for the run; sampled with `start`.
- `start` in 1: request a run.
- `busy` out 1: high in every state except IDLE.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer accepts `result`.
- `result` out 10: accumulated dot product.

## Operation
- FSM has four states: IDLE, CLEAR, RUN, HOLD.
- **IDLE**
  - `wr_en` writes `{wr_a, wr_b}` into the entry at `wr_addr`.
  - On `start`, latch `min(len, DEPTH)` into the term count and go to CLEAR.
- **CLEAR** (one cycle)
  - Accumulator <= 0, index <= 0.
  - If the term count is 0, go to HOLD; otherwise go to RUN.
- **RUN**
  - Each cycle: accumulator <= accumulator + `a[index]*b[index]`, index++.
  - After the cycle that processes index = count-1, go to HOLD.
- **HOLD**
  - `out_valid` = 1 and `result` = accumulator, held stable.
  - On `out_valid && out_ready`, go to IDLE.
- **Arithmetic**
  - The product is 8-bit unsigned, zero-extended to 10 bits.
  - Without `MAC_SAT_EN`, the sum wraps modulo 1024.
- **Ignored inputs**
  - `wr_en` is ignored outside IDLE; the buffer is frozen during a run.
  - `start` is ignored outside IDLE, including the HOLD cycle in which the handshake completes.
  - `out_ready` is ignored outside HOLD.
- **Simultaneous `wr_en` and `start` in IDLE**
  - The write takes effect.
  - The run reads the updated entry, because the first read occurs in RUN.
- **Buffer**
  - Unaffected by the completion of a run.
  - Contents are retained between runs, so weights can be reused across runs.

## Timing
- **Reset**
  - State = IDLE.
  - `busy` = 0, `out_valid` = 0, `result` = 0.
  - Accumulator, index and term count = 0.
  - All buffer entries = 0.
- **Reset mid-run** (any state): same values on the next edge. Any in-flight result is discarded with no `out_valid`.
- **Latency**
  - `start` sampled at edge T.
  - CLEAR occupies cycle T+1.
  - RUN occupies cycles T+2 … T+1+len.
  - `out_valid` rises at T+2+len; for len=0, `out_valid` rises at T+2.
- **Handshake**
  - `out_valid` stays high until the first cycle with `out_ready` = 1.
  - `busy` and `out_valid` drop on the following edge.
  - A new `start` is accepted at the earliest one cycle after that edge.
- **Throughput**: len+3 cycles per run with `out_ready` held high.
- **`busy`**: rises the cycle after `start` is sampled.
- **`result`**: holds its last value in IDLE; it is cleared only by CLEAR or reset.

## Configuration
- Macro: `MAC_SAT_EN`.
- **Defined**: each accumulation clamps at 1023. Once the accumulator reaches 1023 it stays there for the rest of the run; no wrap.
- **Undefined**: the accumulation wraps modulo 1024, with no saturation logic.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Basic run**
  - Stimulus: load a=`1,2,3,4`, b=`5,6,7,8` at addresses 0–3; `start` with len=4.
  - Required: `result`=70; `out_valid` at T+6; `busy` high from T+1 until after the handshake.
- **Overflow**
  - Stimulus: all 8 entries a=b=15; `start` with len=8.
  - Required: `result`=776 without `MAC_SAT_EN`; `result`=1023 with it.
- **Degenerate lengths**
  - Stimulus: len=0.
  - Required: `out_valid` at T+2 with `result`=0.
  - Stimulus: len=12.
  - Required: clamped to 8 terms; `out_valid` at T+10.
- **Backpressure**
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Required: `result` stable and `out_valid` held throughout; a `start` pulse in HOLD is ignored.
  - Stimulus: then assert `out_ready`.
  - Required: IDLE on the next edge.
- **Frozen buffer**
  - Stimulus: `wr_en` to address 0 during RUN.
  - Required: the run result is unchanged; the next run with the same operands gives the same sum.
- **Reset mid-run**
  - Stimulus: assert `rst` during RUN.
  - Required: all outputs 0 on the next edge; a fresh run after reloading the buffer returns the correct sum.
